// File: rtl/osd_vram_writer.sv
// OSD VRAM writer: captures rising edges of the OSD write vector, queues them
// in a small FIFO and drains the queue into the text/colour RAM write ports
// whenever the RAM arbiter grants access. Single clock domain (CLK_25M).
// Optional clear-sweep command enabled by defining OSD_VRAM_CLEAR_CMD_EN.
module osd_vram_writer #(
  parameter int unsigned FIFO_AW   = 2,
  parameter logic [9:0]  VRAM_SIZE = 10'd960
`ifdef OSD_VRAM_CLEAR_CMD_EN
  ,
  parameter logic [5:0]  CLR_COLOR = 6'h0F
`endif
) (
  input  logic        CLK_25M,
  input  logic        SRST_25M,
  input  logic [24:0] OSDWrVector,
  input  logic        wr_gnt,
  output logic        txt_we,
  output logic [9:0]  txt_addr,
  output logic [6:0]  txt_data,
  output logic        col_we,
  output logic [9:0]  col_addr,
  output logic [5:0]  col_data,
  output logic        fifo_full,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

`ifdef OSD_VRAM_CLEAR_CMD_EN
  typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;
  localparam logic [9:0] LAST_ADDR = VRAM_SIZE - 10'd1;
  logic [9:0] clr_cnt, clr_nxt;
`else
  typedef enum logic [0:0] {ST_RUN} state_t;
`endif

  state_t state, state_nxt;

  logic [1:0]       wrctrl;
  logic [1:0]       prev_ctrl;
  logic [24:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full;
  logic             capture, push, drop_push, pop, pop_oor, drop_inc;
  logic [24:0]      head;
  logic [1:0]       h_ctrl;
  logic [9:0]       h_addr;
  logic [12:0]      h_data;

  logic             t_we_nxt, c_we_nxt;
  logic [9:0]       addr_nxt;
  logic [9:0]       wr_addr;
  logic [6:0]       tdata_nxt;
  logic [5:0]       cdata_nxt;

  assign wrctrl  = OSDWrVector[24:23];
  assign capture = (wrctrl != 2'b00) && (prev_ctrl == 2'b00);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign head   = mem[rd_ptr[FIFO_AW-1:0]];
  assign h_ctrl = head[24:23];
  assign h_addr = head[22:13];
  assign h_data = head[12:0];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = capture && (!full || pop);
  assign drop_push = capture && !push;
  assign drop_inc  = drop_push | pop_oor;

  assign fifo_full = full;
  assign txt_addr  = wr_addr;
  assign col_addr  = wr_addr;
`ifdef OSD_VRAM_CLEAR_CMD_EN
  assign busy = !empty | (state == ST_CLEAR);
`else
  assign busy = !empty;
`endif

  // State register (and sweep counter when the clear command is built in).
  always_ff @(posedge CLK_25M) begin
    if (SRST_25M) begin
      state <= ST_RUN;
`ifdef OSD_VRAM_CLEAR_CMD_EN
      clr_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef OSD_VRAM_CLEAR_CMD_EN
      clr_cnt <= clr_nxt;
`endif
    end
  end

  // Next-state, pop decision and next RAM-port values.
  always_comb begin
    state_nxt = state;
`ifdef OSD_VRAM_CLEAR_CMD_EN
    clr_nxt   = clr_cnt;
`endif
    pop       = 1'b0;
    pop_oor   = 1'b0;
    t_we_nxt  = 1'b0;
    c_we_nxt  = 1'b0;
    addr_nxt  = wr_addr;
    tdata_nxt = txt_data;
    cdata_nxt = col_data;
    unique case (state)
      ST_RUN: begin
        if (!empty && wr_gnt) begin
          pop = 1'b1;
`ifdef OSD_VRAM_CLEAR_CMD_EN
          if (h_ctrl == 2'b11 && h_addr == 10'h3FF) begin
            state_nxt = ST_CLEAR;
            clr_nxt   = '0;
          end else
`endif
          if (h_addr >= VRAM_SIZE) begin
            pop_oor = 1'b1;
          end else begin
            t_we_nxt  = h_ctrl[0];
            c_we_nxt  = h_ctrl[1];
            addr_nxt  = h_addr;
            tdata_nxt = h_data[6:0];
            cdata_nxt = {h_data[12:11], h_data[10:7]};
          end
        end
      end
`ifdef OSD_VRAM_CLEAR_CMD_EN
      ST_CLEAR: begin
        if (wr_gnt) begin
          t_we_nxt  = 1'b1;
          c_we_nxt  = 1'b1;
          addr_nxt  = clr_cnt;
          tdata_nxt = '0;
          cdata_nxt = CLR_COLOR;
          clr_nxt   = clr_cnt + 10'd1;
          if (clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
        end
      end
`endif
      default: ;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK_25M) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= OSDWrVector;
  end

  // Pointers, edge-detect register, drop counter and registered RAM ports.
  always_ff @(posedge CLK_25M) begin
    if (SRST_25M) begin
      prev_ctrl <= 2'b00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      txt_we    <= 1'b0;
      col_we    <= 1'b0;
      wr_addr   <= '0;
      txt_data  <= '0;
      col_data  <= '0;
    end else begin
      prev_ctrl <= wrctrl;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      txt_we   <= t_we_nxt;
      col_we   <= c_we_nxt;
      wr_addr  <= addr_nxt;
      txt_data <= tdata_nxt;
      col_data <= cdata_nxt;
    end
  end

endmodule

// File: tb/tb_osd_vram_writer.sv
// Testbench for osd_vram_writer: directed steps plus a random phase, checked
// every cycle against a queue-based reference model of the write path.
module tb_osd_vram_writer;

  logic        clk = 1'b0;
  logic        srst;
  logic [24:0] vec;
  logic        gnt;
  logic        txt_we, col_we, fifo_full, busy;
  logic [9:0]  txt_addr, col_addr;
  logic [6:0]  txt_data;
  logic [5:0]  col_data;
  logic [7:0]  drop_cnt;

  osd_vram_writer #(.FIFO_AW(2), .VRAM_SIZE(10'd960)) dut (
    .CLK_25M    (clk),
    .SRST_25M   (srst),
    .OSDWrVector(vec),
    .wr_gnt     (gnt),
    .txt_we     (txt_we),
    .txt_addr   (txt_addr),
    .txt_data   (txt_data),
    .col_we     (col_we),
    .col_addr   (col_addr),
    .col_data   (col_data),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: command queue of depth 4, previous wrctrl,
  // saturating drop count, sweep flag/index, expected port values.
  logic [24:0] q[$];
  logic [1:0]  m_prev;
  int          m_drop;
  bit          m_clear;
  int          m_clr;
  bit          e_twe, e_cwe;
  int          e_addr, e_tdata, e_cdata;
  int          nwrites;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the current inputs, clock the DUT,
  // then compare outputs.
  task automatic step();
    logic [1:0]  c;
    logic [24:0] e;
    bit cap, drop, oor;
    c = vec[24:23];
    e_twe = 0;
    e_cwe = 0;
    oor   = 0;
    if (srst) begin
      q.delete();
      m_prev = 2'b00; m_drop = 0; m_clear = 0; m_clr = 0;
      e_addr = 0; e_tdata = 0; e_cdata = 0;
    end else begin
      cap    = (c != 2'b00) && (m_prev == 2'b00);
      m_prev = c;
      if (m_clear) begin
        if (gnt) begin
          e_twe = 1; e_cwe = 1;
          e_addr = m_clr; e_tdata = 0; e_cdata = 6'h0F;
          if (m_clr == 959) m_clear = 0;
          m_clr++;
        end
      end else if (gnt && q.size() > 0) begin
        e = q.pop_front();
`ifdef OSD_VRAM_CLEAR_CMD_EN
        if (e[24:23] == 2'b11 && e[22:13] == 10'h3FF) begin
          m_clear = 1;
          m_clr   = 0;
        end else
`endif
        if (e[22:13] >= 960) begin
          oor = 1;
        end else begin
          e_twe   = e[23];
          e_cwe   = e[24];
          e_addr  = e[22:13];
          e_tdata = e[6:0];
          e_cdata = e[12:7];
        end
      end
      drop = cap && (q.size() == 4);
      if (cap && !drop) q.push_back(vec);
      if ((drop || oor) && m_drop < 255) m_drop++;
    end
    @(posedge clk);
    #1;
    if (txt_we) nwrites++;
    chk("txt_we", txt_we, e_twe);
    chk("col_we", col_we, e_cwe);
    chk("busy", busy, (q.size() > 0 || m_clear) ? 1 : 0);
    chk("fifo_full", fifo_full, (q.size() == 4) ? 1 : 0);
    chk("drop_cnt", drop_cnt, m_drop);
    if (e_twe) begin
      chk("txt_addr", txt_addr, e_addr);
      chk("txt_data", txt_data, e_tdata);
    end
    if (e_cwe) begin
      chk("col_addr", col_addr, e_addr);
      chk("col_data", col_data, e_cdata);
    end
  endtask

  task automatic pulse(input logic [1:0] c, input logic [9:0] a, input logic [12:0] d,
                       input int hold);
    vec = {c, a, d};
    repeat (hold) step();
    vec[24:23] = 2'b00;
    step();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_txt_we"}, txt_we, 0);
    chk({tag, "_col_we"}, col_we, 0);
    chk({tag, "_txt_addr"}, txt_addr, 0);
    chk({tag, "_col_addr"}, col_addr, 0);
    chk({tag, "_txt_data"}, txt_data, 0);
    chk({tag, "_col_data"}, col_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
  endtask

  initial begin
    int k;
    srst = 1'b1; vec = '0; gnt = 1'b0; nwrites = 0;
    m_prev = 0; m_drop = 0; m_clear = 0; m_clr = 0;
    step();
    do_reset();
    chk_zero("reset");

    // Single write held high for 10 cycles: one strobe at N+2.
    gnt = 1'b1;
    vec = {2'b11, 10'd5, 13'h1ABC};
    step();
    step();
    chk("t1_txt_we", txt_we, 1);
    chk("t1_col_we", col_we, 1);
    chk("t1_addr", txt_addr, 5);
    chk("t1_tdata", txt_data, 7'h3C);
    chk("t1_cdata", col_data, 6'h35);
    repeat (8) step();
    chk("t1_once", txt_we, 0);
    vec[24:23] = 2'b00;
    repeat (3) step();

    // Overflow with grant held low, then drain.
    do_reset();
    gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(2'b01, 10'(10 + i), 13'(i), 1);
      if (i == 3) chk("t2_full", fifo_full, 1);
    end
    chk("t2_drop", drop_cnt, 2);
    gnt = 1'b1;
    nwrites = 0;
    repeat (6) step();
    chk("t2_nwrites", nwrites, 4);
    chk("t2_idle", busy, 0);

    // Full FIFO with a pop and a capture in the same cycle.
    do_reset();
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) pulse(2'b10, 10'(100 + i), 13'h0F80, 1);
    chk("t3_full", fifo_full, 1);
    gnt = 1'b1;
    vec = {2'b11, 10'd200, 13'h0155};
    step();
    chk("t3_drop", drop_cnt, 0);
    chk("t3_still_full", fifo_full, 1);
    vec[24:23] = 2'b00;
    repeat (8) step();

    // Out-of-range address, then counter saturation.
    do_reset();
    gnt = 1'b1;
    pulse(2'b10, 10'd960, 13'h1FFF, 1);
    repeat (3) step();
    chk("t4_oor", drop_cnt, 1);
    for (int i = 0; i < 300; i++) pulse(2'b01, 10'd1000, 13'(i), 1);
    repeat (4) step();
    chk("t4_sat", drop_cnt, 8'hFF);

    // Clear command.
    do_reset();
`ifdef OSD_VRAM_CLEAR_CMD_EN
    gnt = 1'b0;
    pulse(2'b11, 10'h3FF, 13'h0, 1);
    pulse(2'b11, 10'd3, 13'h0042, 1);
    nwrites = 0;
    k = 0;
    while ((busy || txt_we) && k < 5000) begin
      gnt = k[0];
      step();
      k++;
    end
    chk("t5_timeout", (k < 5000) ? 1 : 0, 1);
    chk("t5_nwrites", nwrites, 961);
`else
    gnt = 1'b1;
    pulse(2'b11, 10'h3FF, 13'h0, 1);
    repeat (3) step();
    chk("t5_clr_dropped", drop_cnt, 1);
`endif

    // Reset while work is outstanding.
    do_reset();
`ifdef OSD_VRAM_CLEAR_CMD_EN
    gnt = 1'b1;
    pulse(2'b11, 10'h3FF, 13'h0, 1);
    k = 0;
    while (!(m_clear && m_clr == 100) && k < 300) begin
      step();
      k++;
    end
    chk("t6_reach", m_clr, 100);
`else
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) pulse(2'b11, 10'(i), 13'h1234, 1);
    chk("t6_pending", busy, 1);
`endif
    do_reset();
    chk_zero("t6");
    gnt = 1'b1;
    nwrites = 0;
    repeat (20) step();
    chk("t6_no_writes", nwrites, 0);

    // Random traffic: pulses, direct non-zero changes, random grant.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      vec = {c, 10'($urandom_range(0, 1000)), 13'($urandom)};
      gnt = ($urandom_range(0, 3) != 0);
      step();
    end
    vec = '0;
    gnt = 1'b1;
    repeat (8) step();
    chk("rand_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_vram_writer.md
Name: osd_vram_writer

Overview:
- Consumes the 25-bit OSD write vector produced by the controller/NIOS stage: {wrctrl[1:0], wraddr[9:0], wrdata[12:0]}.
- Detects each write command, queues it in a small FIFO, and drains the queue into the OSD text/colour RAM write ports. A RAM write is issued only in cycles where the RAM arbiter grants access.
- Sits between the NIOS-side controller block and the OSD text/colour buffers, all in the CLK_25M domain.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (default depth 4 entries).
- VRAM_SIZE, 10'd960, number of valid character cells; valid addresses are 0..VRAM_SIZE-1.
- CLR_COLOR, 6'h0F, colour word written during a clear sweep (Optional Feature).

Ports:
- CLK_25M  in  1  system clock.
- SRST_25M  in  1  synchronous reset, active-high.
- OSDWrVector  in  25  [24:23] wrctrl, [22:13] wraddr, [12:0] wrdata.
- wr_gnt  in  1  RAM arbiter grant; a write may issue only in a cycle where wr_gnt=1.
- txt_we  out  1  text RAM write enable.
- txt_addr  out  10  text RAM address.
- txt_data  out  7  character code, taken from wrdata[6:0].
- col_we  out  1  colour RAM write enable.
- col_addr  out  10  colour RAM address.
- col_data  out  6  colour word: {bg wrdata[12:11], fg wrdata[10:7]}.
- fifo_full  out  1  FIFO holds 2^FIFO_AW entries.
- busy  out  1  FIFO non-empty or a clear sweep is running.
- drop_cnt  out  8  count of dropped plus out-of-range commands; saturates at 8'hFF.

Behaviour:
- Reset (SRST_25M sampled high at a clock edge):
  - All outputs go to 0.
  - FIFO is emptied and the previous-wrctrl register is cleared to 2'b00.
  - Reset asserted mid-sweep or with a non-empty FIFO aborts all work; any pending write is lost.
- Write protocol:
  - Firmware sets wraddr and wrdata, raises wrctrl to a non-zero value, then returns wrctrl to 2'b00.
  - A command is captured at cycle N when wrctrl != 0 and the registered previous wrctrl == 0.
  - A wrctrl value held non-zero for several cycles yields exactly one command.
  - A direct change between two non-zero wrctrl values yields no new command.
- wrctrl coding:
  - 01: write text only.
  - 10: write colour only.
  - 11: write text and colour.
- Push:
  - The capture at cycle N is written into the FIFO, visible at N+1.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the command is dropped and drop_cnt increments (saturating).
- Pop and write:
  - In state RUN, a pop occurs when the FIFO is non-empty and wr_gnt=1.
  - The write strobes are registered: they assert one cycle after the pop and last for exactly one cycle.
  - Minimum latency from capture to strobe is 2 cycles, i.e. we=1 at cycle N+2.
  - txt_addr and col_addr both equal the entry's wraddr.
  - An entry with wraddr >= VRAM_SIZE is popped with no strobe, and drop_cnt increments.
  - If wr_gnt is low, the head entry is held; nothing is lost.
- States:
  - RUN: normal drain, as above.
  - CLEAR: present only with the Optional Feature.
- Pointer and counter arithmetic:
  - FIFO pointers are FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1).
  - full is when the pointers differ only in their MSB; empty is when they are equal.
  - drop_cnt can increment by at most 1 per cycle. If a dropped push and an out-of-range pop happen in the same cycle, the count still increments by exactly 1.
- Outputs:
  - fifo_full is combinational from the pointers.
  - busy = !empty | (state==CLEAR).

Optional Feature:
- Macro: OSD_VRAM_CLEAR_CMD_EN.
- Enabled:
  - A popped entry with wrctrl==11 and wraddr==10'h3FF starts a clear sweep: state RUN->CLEAR and clr_cnt=0.
  - In CLEAR, each cycle with wr_gnt=1 writes txt_data=0 and col_data=CLR_COLOR to address clr_cnt, asserting txt_we and col_we, then increments clr_cnt.
  - After address VRAM_SIZE-1 is written, the state returns to RUN.
  - The clear command itself produces no other write.
  - Pushes are still accepted during CLEAR; pops stall until the sweep ends.
  - A second clear command queued during a sweep runs after the current sweep completes.
- Disabled:
  - No CLEAR state exists.
  - Address 10'h3FF is treated as a normal out-of-range address: it is dropped and counted.

Test Plan:
- Single write: wrctrl 00->11 with wraddr=10'd5, wrdata=13'h1ABC, wr_gnt=1 -> at N+2: txt_we=col_we=1, addr=5, txt_data=7'h3C, col_data=6'h35; one cycle only, although wrctrl is held high for 10 cycles.
- Overflow: wr_gnt=0, six separate 00->01 pulses -> fifo_full=1 after the 4th; drop_cnt=2. Raise wr_gnt -> four txt_we pulses on consecutive cycles with addresses in order; busy drops after the last.
- Full plus simultaneous pop: FIFO full, wr_gnt=1, and a capture in the same cycle -> push accepted, drop_cnt unchanged.
- Out of range: wraddr=10'd960, wrctrl=10 -> no col_we, drop_cnt +1. Saturation: 300 drops -> drop_cnt=8'hFF.
- Clear (macro enabled): queue clear command, then a write to addr 3 -> 960 sweep writes (0..959, col_data=6'h0F), gated by wr_gnt toggling 50%; then the addr-3 write. Macro disabled -> the clear command is dropped and counted.
- Reset mid-sweep: assert SRST_25M at clr_cnt=100 -> next cycle all outputs 0, busy=0, and no further writes occur.
